// File: rtl/program_loader.sv
// ============================================================================
// program_loader : framed byte-stream loader for instruction memory (XOR checksum)
// Revision 1.0
// ============================================================================
`default_nettype none

module program_loader #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CHECK, FIN} state_t;

  state_t        state, state_nxt;
  logic [7:0]    base, len, idx, csum;
  logic [CW-1:0] idle_cnt;
  logic          accept, timed_out;

  assign in_ready  = (state == ADDR) || (state == LEN) || (state == DATA) || (state == CHECK);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN) && !error;
  assign accept    = in_valid && in_ready;
  assign timed_out = in_ready && !accept && (idle_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_start) state_nxt = ADDR;
      ADDR:    if (accept) state_nxt = LEN;
      LEN:     if (accept) state_nxt = DATA;
      // A length byte of 0x00 wraps len-1 to 0xFF, giving 256 data bytes
      DATA:    if (accept && (idx == len - 8'd1)) state_nxt = CHECK;
      CHECK:   if (accept) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timed_out) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      base      <= 8'h00;
      len       <= 8'h00;
      idx       <= 8'h00;
      csum      <= 8'h00;
      idle_cnt  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= 8'h00;
      mem_wdata <= 8'h00;
      error     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if ((state == IDLE) && load_start) begin
        csum     <= 8'h00;
        error    <= 1'b0;
        idle_cnt <= '0;
        idx      <= 8'h00;
      end
      if (accept) begin
        idle_cnt <= '0;
        csum     <= csum ^ in_data;
        case (state)
          ADDR:  base <= in_data;
          LEN:   begin
            len <= in_data;
            idx <= 8'h00;
          end
          DATA:  begin
            mem_we    <= 1'b1;
            mem_addr  <= base + idx;
            mem_wdata <= in_data;
            idx       <= idx + 8'd1;
          end
          CHECK: error <= (in_data != csum);
          default: ;
        endcase
      end else if (in_ready) begin
        if (idle_cnt == TO_LAST) error <= 1'b1;
        else                     idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// tb_program_loader : directed + randomized frames against a frame-level model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_program_loader;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, mem_we, busy, done, error;
  logic [7:0] mem_addr, mem_wdata;

  program_loader #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail = 0;
  logic [7:0] model_mem [256];
  logic [7:0] dut_mem [256];
  logic [7:0] fb [256];
  logic [7:0] last_addr = 8'h00;
  logic [7:0] last_wdata = 8'h00;

  // Observed memory image, captured mid-cycle
  always @(negedge clk) if (mem_we) dut_mem[mem_addr] = mem_wdata;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("start_busy", busy, 1);
    check("start_ready", in_ready, 1);
    check("start_err_clr", error, 0);
    check("start_done", done, 0);
  endtask

  task automatic send_frame(input logic [7:0] base, input logic [7:0] len, input bit good,
                            input int gap_max, input int fixed_gap, input bit noise);
    int         n;
    int         gap;
    logic [7:0] x;
    logic [7:0] b[$];
    logic [7:0] a;
    bit         exp_err;
    n = (len == 8'h00) ? 256 : int'(len);
    b.push_back(base);
    b.push_back(len);
    for (int k = 0; k < n; k++) b.push_back(fb[k]);
    x = 8'h00;
    foreach (b[j]) x = x ^ b[j];
    exp_err = !good;
    b.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
    start_frame();
    for (int i = 0; i < n + 3; i++) begin
      gap = (fixed_gap > 0 && i >= 3 && i <= n + 1) ? fixed_gap
          : (gap_max > 0 ? int'($urandom_range(0, gap_max)) : 0);
      for (int g = 0; g < gap; g++) begin
        in_valid   = 1'b0;
        in_data    = 8'($urandom);
        load_start = noise ? 1'($urandom) : 1'b0;
        tick();
        check("stall_we", mem_we, 0);
        check("stall_addr_hold", mem_addr, last_addr);
        check("stall_wdata_hold", mem_wdata, last_wdata);
        check("stall_ready", in_ready, 1);
        check("stall_busy", busy, 1);
      end
      in_valid   = 1'b1;
      in_data    = b[i];
      load_start = noise ? 1'($urandom) : 1'b0;
      tick();
      in_valid   = 1'b0;
      load_start = 1'b0;
      if (i >= 2 && i <= n + 1) begin
        a = 8'((int'(base) + i - 2) % 256);
        check("wr_we", mem_we, 1);
        check("wr_addr", mem_addr, a);
        check("wr_data", mem_wdata, b[i]);
        model_mem[a] = b[i];
        last_addr    = a;
        last_wdata   = b[i];
      end else begin
        check("nowr_we", mem_we, 0);
      end
      if (i < n + 2) begin
        check("frame_ready", in_ready, 1);
        check("frame_done", done, 0);
      end else begin
        check("fin_ready", in_ready, 0);
        check("fin_busy", busy, 1);
        check("fin_done", done, !exp_err);
        check("fin_error", error, exp_err);
      end
    end
    tick();
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_ready", in_ready, 0);
    check("idle_error", error, exp_err);
    check("idle_we", mem_we, 0);
  endtask

  initial begin
    int mism;
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 8'h00;
      dut_mem[i]   = 8'h00;
    end

    rst = 1'b0;
    tick();
    tick();
    check("rst_ready", in_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    rst = 1'b1;
    tick();

    // Basic load
    fb[0] = 8'hA1; fb[1] = 8'hB2; fb[2] = 8'hC3;
    send_frame(8'h10, 8'h03, 1'b1, 0, 0, 1'b0);
    // Address wrap
    fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h03;
    send_frame(8'hFE, 8'h03, 1'b1, 0, 0, 1'b0);
    // Bad checksum, error must stay up until the next load_start
    fb[0] = 8'hA1; fb[1] = 8'hB2; fb[2] = 8'hC3;
    send_frame(8'h10, 8'h03, 1'b0, 0, 0, 1'b0);
    for (int t = 0; t < 3; t++) begin
      tick();
      check("err_sticky", error, 1);
      check("err_no_done", done, 0);
    end
    // Five-cycle stalls between data bytes
    fb[0] = 8'h5A; fb[1] = 8'h6B; fb[2] = 8'h7C; fb[3] = 8'h8D;
    send_frame(8'h20, 8'h04, 1'b1, 0, 5, 1'b0);

    // Timeout after the length byte
    start_frame();
    in_valid = 1'b1; in_data = 8'h40; tick();
    in_valid = 1'b1; in_data = 8'h05; tick();
    in_valid = 1'b0;
    for (int t = 1; t <= TO; t++) begin
      tick();
      check("to_we", mem_we, 0);
      check("to_done", done, 0);
      check("to_error", error, (t == TO) ? 1'b1 : 1'b0);
      check("to_busy", busy, (t == TO) ? 1'b0 : 1'b1);
    end
    tick();
    check("to_err_hold", error, 1);
    check("to_idle_ready", in_ready, 0);

    // Reset in the middle of the data phase
    start_frame();
    in_valid = 1'b1; in_data = 8'h80; tick();
    in_valid = 1'b1; in_data = 8'h04; tick();
    in_valid = 1'b1; in_data = 8'h11; tick();
    check("rd_wr0", mem_addr, 8'h80);
    model_mem[8'h80] = 8'h11;
    in_valid = 1'b1; in_data = 8'h22; tick();
    check("rd_wr1", mem_addr, 8'h81);
    model_mem[8'h81] = 8'h22;
    rst = 1'b0; in_valid = 1'b1; in_data = 8'h33; tick();
    check("rd_ready", in_ready, 0);
    check("rd_we", mem_we, 0);
    check("rd_addr", mem_addr, 0);
    check("rd_wdata", mem_wdata, 0);
    check("rd_busy", busy, 0);
    check("rd_done", done, 0);
    check("rd_error", error, 0);
    rst = 1'b1; in_valid = 1'b0;
    last_addr = 8'h00; last_wdata = 8'h00;
    tick();
    check("rd_idle_busy", busy, 0);

    // Randomized frames with stalls, stray load_start pulses and occasional bad checksums
    for (int f = 0; f < 12; f++) begin
      logic [7:0] len;
      len = (f == 5) ? 8'h00 : 8'($urandom_range(1, 24));
      for (int k = 0; k < 256; k++) fb[k] = 8'($urandom);
      send_frame(8'($urandom), len, ($urandom_range(0, 3) != 0), 2, 0, 1'b1);
      for (int t = 0; t < int'($urandom_range(0, 3)); t++) tick();
    end

    mism = 0;
    for (int i = 0; i < 256; i++) if (dut_mem[i] !== model_mem[i]) mism++;
    check("mem_image", 16'(mism), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
